div_ctrl: RTL and testbench

Sequencer for the EXE-stage iterative divider. It accepts DIV/DIVU from the execute stage and runs a 32-iteration restoring division. While it runs, it holds the pipeline through the EXE stall request. It then presents a 64-bit {remainder, quotient} result in the same format as `exe_mul`, for HI/LO write-back through the EXE/MEM register.

---
 rtl/div_ctrl_pkg.sv | 27 ++
 rtl/div_step.sv | 24 ++
 rtl/div_ctrl.sv | 114 +++++++++++
 tb/tb_div_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared opcodes, state encodings and bus widths for the EXE-stage divider.
`timescale 1ns/1ps
`default_nettype none
package div_ctrl_pkg;

  localparam int ALUOP_W      = 8;
  localparam int DOUBLE_REG_W = 64;
  localparam int CNT_W        = 6;

  localparam logic [ALUOP_W-1:0] MINIMIPS32_NOP  = 8'h00;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_DIV  = 8'h16;
  localparam logic [ALUOP_W-1:0] MINIMIPS32_DIVU = 8'h17;

  localparam logic [DOUBLE_REG_W-1:0] ZERO_DWORD = '0;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on a {remainder, dividend} pair.
`timescale 1ns/1ps
`default_nettype none
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               q_bit
);

  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] diff;

  // Upper WIDTH+1 bits after the left shift; the difference always fits WIDTH bits when taken.
  assign upper   = acc_in[2*WIDTH-1:WIDTH-1];
  assign q_bit   = (upper >= {1'b0, divisor});
  assign diff    = upper[WIDTH-1:0] - divisor;
  assign acc_out = q_bit ? {diff, acc_in[WIDTH-2:0], 1'b1}
                         : {upper[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the iterative DIV/DIVU unit; stalls EXE and returns {remainder, quotient}.
`timescale 1ns/1ps
`default_nettype none
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst,
  input  logic [ALUOP_W-1:0]   exe_aluop,
  input  logic [WIDTH-1:0]     exe_src1,
  input  logic [WIDTH-1:0]     exe_src2,
  input  logic                 flush,
  output logic                 stallreq_div,
  output logic                 div_ready,
  output logic [2*WIDTH-1:0]   div_result
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   divisor;
  logic               neg_q;
  logic               neg_r;
  logic               q_bit;

  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign start     = (exe_aluop == MINIMIPS32_DIV) || (exe_aluop == MINIMIPS32_DIVU);
  assign signed_op = (exe_aluop == MINIMIPS32_DIV);

  assign dvd_mag = (signed_op && exe_src1[WIDTH-1]) ? (~exe_src1 + ONE) : exe_src1;
  assign dvs_mag = (signed_op && exe_src2[WIDTH-1]) ? (~exe_src2 + ONE) : exe_src2;

  div_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .acc_in  (acc),
    .divisor (divisor),
    .acc_out (acc_nxt),
    .q_bit   (q_bit)
  );

  // Sign correction applied to the final step so the result lands registered on entry to END.
  assign quo_fix = neg_q ? (~acc_nxt[WIDTH-1:0] + ONE) : acc_nxt[WIDTH-1:0];
  assign rem_fix = neg_r ? (~acc_nxt[2*WIDTH-1:WIDTH] + ONE) : acc_nxt[2*WIDTH-1:WIDTH];

  // END already carries a stall-free cycle, so the retiring DIV never re-triggers.
  assign stallreq_div = start & (state != DIV_END) & ~cpu_rst;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= DIV_FREE;
      cnt        <= '0;
      acc        <= '0;
      divisor    <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_ready  <= DIV_NOT_READY;
      div_result <= '0;
    end else begin
      div_ready <= DIV_NOT_READY;
      if (flush) begin
        state <= DIV_FREE;
      end else begin
        case (state)
          DIV_FREE: begin
            if (start) begin
              if (exe_src2 == '0) begin
                state <= DIV_BYZERO;
              end else begin
                state   <= DIV_ON;
                cnt     <= '0;
                acc     <= {{WIDTH{1'b0}}, dvd_mag};
                divisor <= dvs_mag;
                neg_q   <= signed_op & (exe_src1[WIDTH-1] ^ exe_src2[WIDTH-1]);
                neg_r   <= signed_op & exe_src1[WIDTH-1];
              end
            end
          end
          DIV_BYZERO: begin
            state      <= DIV_END;
            div_result <= '0;
            div_ready  <= DIV_READY;
          end
          DIV_ON: begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state      <= DIV_END;
              div_result <= {rem_fix, quo_fix};
              div_ready  <= DIV_READY;
            end
          end
          default: begin
            state <= DIV_FREE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl timing, results, flush and reset behaviour.
`timescale 1ns/1ps
`default_nettype none
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ALUOP_W-1:0] aluop = MINIMIPS32_NOP;
  logic [31:0]        src1 = '0;
  logic [31:0]        src2 = '0;
  logic               flush = 1'b0;
  logic               stall;
  logic               ready;
  logic [63:0]        result;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] last_exp = '0;

  always #10 clk = ~clk;

  div_ctrl #(.WIDTH(32)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst      (rst),
    .exe_aluop    (aluop),
    .exe_src1     (src1),
    .exe_src2     (src2),
    .flush        (flush),
    .stallreq_div (stall),
    .div_ready    (ready),
    .div_result   (result)
  );

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [ALUOP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    aluop = op;
    src1  = a;
    src2  = b;
    flush = 1'b0;
  endtask

  // Called in cycle 0 of a division; expects stall for lat cycles then a ready pulse.
  task automatic track(input int lat, input logic [63:0] exp, input string tag);
    #1;
    for (int c = 0; c < lat; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("%s_busy_c%0d", tag, c), {stall, ready, result}, {2'b10, last_exp});
      if (c == 1) begin
        src1 = $urandom;
        src2 = $urandom;
      end
    end
    @(negedge clk);
    #1;
    check($sformatf("%s_done", tag), {stall, ready, result}, {2'b01, exp});
    last_exp = exp;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    aluop = MINIMIPS32_NOP;
    flush = 1'b0;
    #1;
    check(tag, {stall, ready, result}, {2'b00, last_exp});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    aluop = MINIMIPS32_DIVU;
    #1;
    check("reset_outputs", {stall, ready, result}, {2'b00, 64'h0});
    aluop = MINIMIPS32_NOP;
    @(negedge clk);
    rst = 1'b0;

    launch(MINIMIPS32_DIVU, 32'd100, 32'd7);
    track(33, 64'h00000002_0000000E, "divu_100_7");
    idle("idle_a");

    launch(MINIMIPS32_DIV, 32'hFFFFFFF9, 32'h00000002);
    track(33, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    idle("idle_b");

    launch(MINIMIPS32_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9);
    track(33, 64'hFFFFFFFE_0000000E, "div_m100_m7");
    idle("idle_c");

    launch(MINIMIPS32_DIVU, 32'hFFFFFFFF, 32'h00000010);
    track(33, 64'h0000000F_0FFFFFFF, "divu_max_16");
    idle("idle_d");

    launch(MINIMIPS32_DIV, 32'h80000000, 32'hFFFFFFFF);
    track(33, 64'h00000000_80000000, "div_overflow");
    idle("idle_e");

    // Flush on cycle 10 with start dropped, then restart on cycle 11.
    launch(MINIMIPS32_DIVU, 32'd1000, 32'd3);
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("flush_pre_c%0d", c), {stall, ready, result}, {2'b10, last_exp});
    end
    @(negedge clk);
    flush = 1'b1;
    aluop = MINIMIPS32_NOP;
    #1;
    check("flush_cycle", {stall, ready, result}, {2'b00, last_exp});
    launch(MINIMIPS32_DIVU, 32'd1000, 32'd3);
    track(33, 64'h00000001_0000014D, "after_flush");
    idle("idle_f");

    launch(MINIMIPS32_DIVU, 32'd5, 32'd0);
    track(2, 64'h0, "divu_by_zero");
    idle("idle_g");

    launch(MINIMIPS32_DIVU, 32'd9, 32'd3);
    track(33, 64'h00000000_00000003, "b2b_first");
    launch(MINIMIPS32_DIV, 32'd9, 32'hFFFFFFFD);
    track(33, 64'h00000000_FFFFFFFD, "b2b_second");
    idle("idle_h");

    // Asynchronous reset mid-division, released with start still held.
    launch(MINIMIPS32_DIVU, 32'd50, 32'd7);
    #1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("rst_pre_c%0d", c), {stall, ready, result}, {2'b10, last_exp});
    end
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", {stall, ready, result}, {2'b00, 64'h0});
    last_exp = '0;
    @(negedge clk);
    src1 = 32'd50;
    src2 = 32'd7;
    rst  = 1'b0;
    track(33, 64'h00000001_00000007, "after_reset");
    idle("idle_i");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
